// File: rtl/avalon_ram_slave.sv
// Avalon-MM RAM responder: word-organised on-chip RAM with byte-enable writes,
// a programmable number of wait states per access and a fixed read latency.
module avalon_ram_slave #(
    parameter int unsigned AW          = 12,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    output logic        avs_waitrequest,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid
);

    localparam int unsigned Depth    = 2 ** AW;
    localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

    logic [31:0]   mem [Depth];
    logic [AW-1:0] word_addr;
    logic          req;
    logic          accept;
    logic          wr_acc;
    logic          rd_acc;
    logic [3:0]    wcnt_q;

    logic [RD_LATENCY-1:0] vld_q;
    logic [31:0]           dat_q [RD_LATENCY];

    // Byte-lane bits and bits above the RAM depth are don't-care (address aliases).
    logic unused_addr;
    assign unused_addr = ^{avs_address[31:AW+2], avs_address[1:0]};

    assign word_addr       = avs_address[AW+1:2];
    assign req             = avs_read | avs_write;
    assign avs_waitrequest = req & (wcnt_q != 4'd0);
    assign accept          = req & ~avs_waitrequest & ~rst;
    // A simultaneous read and write is treated as a write only.
    assign wr_acc          = accept & avs_write;
    assign rd_acc          = accept & avs_read & ~avs_write;

    // Wait-state counter: counts down while a request is stalled, reloads otherwise.
    always_ff @(posedge clk) begin
        if (rst || !req || accept) begin
            wcnt_q <= WaitInit;
        end else begin
            wcnt_q <= wcnt_q - 4'd1;
        end
    end

    // RAM write port with per-byte enables; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < 4; i++) begin
                if (avs_byteenable[i]) begin
                    mem[word_addr][8*i +: 8] <= avs_writedata[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline: data stages only advance behind a valid, so the last stage holds
    // the previous read value while readdatavalid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                dat_q[0] <= mem[word_addr];
            end
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign avs_readdatavalid = vld_q[RD_LATENCY-1];
    assign avs_readdata      = dat_q[RD_LATENCY-1];

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Scoreboard bench for avalon_ram_slave: three instances with different wait-state and
// latency settings, driven by directed and random accesses against a word-array model.
module tb_avalon_ram_slave;

    localparam int unsigned AW   = 6;
    localparam int          NDUT = 3;
    localparam int          WAITS [NDUT] = '{0, 3, 0};
    localparam int          LATS  [NDUT] = '{1, 1, 3};

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr   [NDUT];
    logic [31:0] wdata  [NDUT];
    logic [3:0]  be     [NDUT];
    logic        rd     [NDUT];
    logic        wr     [NDUT];
    logic        wreq   [NDUT];
    logic        rvalid [NDUT];
    logic [31:0] rdata  [NDUT];

    logic [31:0] model [NDUT][2**AW];
    exp_t        sb    [NDUT][$];
    int          cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    avalon_ram_slave #(.AW(AW), .WAIT_CYCLES(WAITS[0]), .RD_LATENCY(LATS[0])) u_dut0 (
        .clk(clk), .rst(rst), .avs_address(addr[0]), .avs_read(rd[0]), .avs_write(wr[0]),
        .avs_writedata(wdata[0]), .avs_byteenable(be[0]), .avs_waitrequest(wreq[0]),
        .avs_readdata(rdata[0]), .avs_readdatavalid(rvalid[0])
    );

    avalon_ram_slave #(.AW(AW), .WAIT_CYCLES(WAITS[1]), .RD_LATENCY(LATS[1])) u_dut1 (
        .clk(clk), .rst(rst), .avs_address(addr[1]), .avs_read(rd[1]), .avs_write(wr[1]),
        .avs_writedata(wdata[1]), .avs_byteenable(be[1]), .avs_waitrequest(wreq[1]),
        .avs_readdata(rdata[1]), .avs_readdatavalid(rvalid[1])
    );

    avalon_ram_slave #(.AW(AW), .WAIT_CYCLES(WAITS[2]), .RD_LATENCY(LATS[2])) u_dut2 (
        .clk(clk), .rst(rst), .avs_address(addr[2]), .avs_read(rd[2]), .avs_write(wr[2]),
        .avs_writedata(wdata[2]), .avs_byteenable(be[2]), .avs_waitrequest(wreq[2]),
        .avs_readdata(rdata[2]), .avs_readdatavalid(rvalid[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every readdatavalid pops the oldest expected read; a read whose due
    // cycle passes without a valid is reported as missing.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NDUT; k++) begin
            if (rvalid[k] === 1'b1) begin
                if (sb[k].size() == 0) begin
                    check($sformatf("dut%0d unexpected readdatavalid", k), 32'(rvalid[k]), 32'd0);
                end else begin
                    e = sb[k].pop_front();
                    check($sformatf("dut%0d readdata", k), rdata[k], e.data);
                    check($sformatf("dut%0d read latency", k), 32'(cyc), 32'(e.due));
                end
            end else if (sb[k].size() != 0 && cyc > sb[k][0].due) begin
                e = sb[k].pop_front();
                check($sformatf("dut%0d missing readdatavalid", k), 32'(rvalid[k]), 32'd1);
            end
        end
    end

    // One Avalon access held until accepted; the model is updated in the accept cycle.
    task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
        int            waits = 0;
        bit            done  = 1'b0;
        logic [AW-1:0] wi;
        rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
        wi = a[AW+1:2];
        while (!done) begin
            @(negedge clk);
            if (wreq[k] === 1'b0) begin
                done = 1'b1;
                if (w) begin
                    for (int i = 0; i < 4; i++) begin
                        if (b[i]) model[k][wi][8*i +: 8] = d[8*i +: 8];
                    end
                end else if (r) begin
                    sb[k].push_back('{data: model[k][wi], due: cyc + LATS[k]});
                end
            end else begin
                waits++;
                if (waits > 40) done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check($sformatf("dut%0d wait cycles", k), 32'(waits), 32'(WAITS[k]));
        rd[k] = 1'b0;
        wr[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Synchronous reset pulse; in-flight reads are expected to be dropped.
    task automatic pulse_reset();
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) sb[k].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        int          sel;
        for (int k = 0; k < NDUT; k++) begin
            rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0; be[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("dut%0d reset readdatavalid", k), 32'(rvalid[k]), 32'd0);
            check($sformatf("dut%0d reset readdata", k), rdata[k], 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("dut%0d idle waitrequest", k), 32'(wreq[k]), 32'd0);
        end
        @(posedge clk);
        #1;

        // Full write then read-back, then partial byte-enable write.
        access(0, 0, 1, 32'h10, 32'h1234_5678, 4'b1111);
        access(0, 1, 0, 32'h10, 32'h0, 4'b0000);
        access(0, 0, 1, 32'h10, 32'hAABB_CCDD, 4'b0101);
        access(0, 1, 0, 32'h10, 32'h0, 4'b1111);
        access(0, 0, 1, 32'h10, 32'hFFFF_FFFF, 4'b0000);
        access(0, 1, 0, 32'h10, 32'h0, 4'b0000);
        idle(3);

        // Wait states: back-to-back reads each see the full count.
        access(1, 0, 1, 32'h8, 32'hDEAD_BEEF, 4'b1111);
        access(1, 1, 0, 32'h8, 32'h0, 4'b0000);
        access(1, 1, 0, 32'h8, 32'h0, 4'b0000);
        idle(3);

        // Pipelined reads with latency 3 return in order on consecutive cycles.
        access(2, 0, 1, 32'h0, 32'd1, 4'b1111);
        access(2, 0, 1, 32'h4, 32'd2, 4'b1111);
        access(2, 0, 1, 32'h8, 32'd3, 4'b1111);
        access(2, 1, 0, 32'h0, 32'h0, 4'b0000);
        access(2, 1, 0, 32'h4, 32'h0, 4'b0000);
        access(2, 1, 0, 32'h8, 32'h0, 4'b0000);
        idle(6);

        // Reset one cycle after a read accept drops the read; RAM keeps its contents.
        access(2, 0, 1, 32'h30, 32'hCAFE_F00D, 4'b1111);
        access(2, 1, 0, 32'h30, 32'h0, 4'b0000);
        pulse_reset();
        idle(6);
        @(negedge clk);
        check("dut2 readdata after reset", rdata[2], 32'd0);
        @(posedge clk);
        #1;
        access(2, 1, 0, 32'h30, 32'h0, 4'b0000);
        idle(6);

        // Read+write together: write wins, then aliased read-back.
        for (int k = 0; k < NDUT; k++) begin
            access(k, 1, 1, 32'h20, 32'h5, 4'b1111);
            idle(5);
            access(k, 1, 0, 32'h20, 32'h0, 4'b0000);
            access(k, 1, 0, 32'h20 + 32'(4 * (2 ** AW)), 32'h0, 4'b0000);
            idle(5);
        end

        // Random traffic on every instance after preloading all words.
        for (int k = 0; k < NDUT; k++) begin
            for (int w = 0; w < 2 ** AW; w++) begin
                access(k, 0, 1, 32'(4 * w), $urandom(), 4'b1111);
            end
            for (int n = 0; n < 60; n++) begin
                sel = int'($urandom_range(0, 9));
                ra  = $urandom();
                if (sel <= 3) access(k, 1, 0, ra, 32'h0, 4'($urandom()));
                else if (sel <= 7) access(k, 0, 1, ra, $urandom(), 4'($urandom()));
                else if (sel == 8) access(k, 1, 1, ra, $urandom(), 4'($urandom()));
                else idle(int'($urandom_range(1, 3)));
            end
            idle(6);
        end

        idle(4);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("dut%0d outstanding reads", k), 32'(sb[k].size()), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
